// File: rtl/interval_timer_if.sv
// OCP slave register port bundle shared by the interval timer and its bus master.
// Signal names keep the direction as seen from the timer (i_ = into the timer).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif

interface interval_timer_if;
    logic [`ADDR_WIDTH-1:0] i_MAddr;
    logic [2:0]             i_MCmd;
    logic [`DATA_WIDTH-1:0] i_MData;
    logic [`BEN_WIDTH-1:0]  i_MByteEn;
    logic                   o_SCmdAccept;
    logic [`DATA_WIDTH-1:0] o_SData;
    logic [1:0]             o_SResp;

    modport master (
        output i_MAddr,
        output i_MCmd,
        output i_MData,
        output i_MByteEn,
        input  o_SCmdAccept,
        input  o_SData,
        input  o_SResp
    );

    modport slave (
        input  i_MAddr,
        input  i_MCmd,
        input  i_MData,
        input  i_MByteEn,
        output o_SCmdAccept,
        output o_SData,
        output o_SResp
    );
endinterface

// File: rtl/interval_timer.sv
// Programmable down-counting interval timer with an OCP register port and a
// one-cycle interrupt pulse on every expiry.
module interval_timer (
    input  logic               clk,
    input  logic               nrst,
    interval_timer_if.slave    bus,
    output logic               o_intr
);

    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_CNTR = 2'd1,
        REG_CURR = 2'd2,
        REG_NONE = 2'd3
    } regSel_t;

    logic                   r_enable;
    logic                   r_reload;
    logic                   r_imask;
    logic [`DATA_WIDTH-1:0] r_cntr;
    logic [`DATA_WIDTH-1:0] r_curr;
    logic [`DATA_WIDTH-1:0] r_sdata;
    logic [1:0]             r_sresp;
    logic                   r_intr;

    logic                   w_isWrite;
    logic                   w_isRead;
    regSel_t                w_sel;
    logic                   w_ctrlWrite;
    logic                   w_cntrWrite;
    logic                   w_expiry;
    logic [`DATA_WIDTH-1:0] w_newCntr;
    logic [`DATA_WIDTH-1:0] w_readData;
    logic                   w_unusedAddr;

    assign w_isWrite    = (bus.i_MCmd == CMD_WRITE);
    assign w_isRead     = (bus.i_MCmd == CMD_READ);
    assign w_sel        = regSel_t'(bus.i_MAddr[3:2]);
    assign w_unusedAddr = &{1'b0, bus.i_MAddr[`ADDR_WIDTH-1:4], bus.i_MAddr[1:0]};

    // CTRL only holds bits in byte 0, so a CTRL write without that lane changes nothing.
    assign w_ctrlWrite  = w_isWrite && (w_sel == REG_CTRL) && bus.i_MByteEn[0];
    assign w_cntrWrite  = w_isWrite && (w_sel == REG_CNTR);
    assign w_expiry     = r_enable && (r_curr <= `DATA_WIDTH'(1));

    assign bus.o_SCmdAccept = w_isWrite | w_isRead;
    assign bus.o_SData      = r_sdata;
    assign bus.o_SResp      = r_sresp;
    assign o_intr           = r_intr;

    always_comb begin
        w_newCntr = r_cntr;
        for (int b = 0; b < `BEN_WIDTH; b++) begin
            if (bus.i_MByteEn[b]) begin
                w_newCntr[8*b +: 8] = bus.i_MData[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_readData = '0;
        case (w_sel)
            REG_CTRL: w_readData = {{(`DATA_WIDTH-3){1'b0}}, r_imask, r_reload, r_enable};
            REG_CNTR: w_readData = r_cntr;
            REG_CURR: w_readData = r_curr;
            default:  w_readData = '0;
        endcase
    end

    // A CTRL write overrides whatever the counter would have done on this edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_enable <= 1'b0;
            r_reload <= 1'b0;
            r_imask  <= 1'b0;
            r_curr   <= '0;
        end else if (w_ctrlWrite) begin
            r_enable <= bus.i_MData[0];
            r_reload <= bus.i_MData[1];
            r_imask  <= bus.i_MData[2];
            if (bus.i_MData[0]) begin
                r_curr <= r_cntr;
            end
        end else if (w_expiry) begin
            if (r_reload) begin
                r_curr <= r_cntr;
            end else begin
                r_curr   <= '0;
                r_enable <= 1'b0;
            end
        end else if (r_enable) begin
            r_curr <= r_curr - `DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cntr <= '0;
        end else if (w_cntrWrite) begin
            r_cntr <= w_newCntr;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sresp <= RESP_NULL;
            r_sdata <= '0;
        end else begin
            r_sdata <= w_isRead ? w_readData : '0;
            if (w_isWrite || w_isRead) begin
                r_sresp <= (w_sel == REG_NONE) ? RESP_ERR : RESP_DVA;
            end else begin
                r_sresp <= RESP_NULL;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_intr <= 1'b0;
        end else begin
            r_intr <= w_expiry && r_imask;
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: fixed vector table, hand-written
// multi-cycle sequences and random traffic against a deadline-based model.
module tb_interval_timer;

    logic clk;
    logic nrst;
    logic intr;

    interval_timer_if bus ();

    interval_timer dut (
        .clk    (clk),
        .nrst   (nrst),
        .bus    (bus),
        .o_intr (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        intr;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] sData;
    logic [1:0]  sResp;
    logic        sIntr;

    // Model: the counter is described by the absolute edge at which it next expires.
    longint      mCyc = 0;
    longint      mDeadline = 0;
    logic        mEn, mRel, mMask;
    logic [31:0] mCntr, mLoad, mHeld;
    logic [31:0] eData;
    logic [1:0]  eResp;
    logic        eIntr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mEn = 0; mRel = 0; mMask = 0;
        mCntr = 0; mLoad = 0; mHeld = 0; mDeadline = 0;
        eData = 0; eResp = 0; eIntr = 0;
    endtask

    function automatic logic [31:0] currNow();
        if (!mEn) return mHeld;
        if (mLoad == 0) return 32'd0;
        return 32'(mDeadline - mCyc + 1);
    endfunction

    function automatic longint periodOf(input logic [31:0] v);
        return (v == 0) ? 64'd1 : longint'(v);
    endfunction

    task automatic modelStep(input logic [2:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] ben);
        logic [1:0]  sel;
        logic        isW, isR, expired;
        logic [31:0] rd;
        mCyc++;
        sel = addr[3:2];
        isW = (cmd == 3'd1);
        isR = (cmd == 3'd2);
        case (sel)
            2'd0:    rd = {29'd0, mMask, mRel, mEn};
            2'd1:    rd = mCntr;
            2'd2:    rd = currNow();
            default: rd = 32'd0;
        endcase
        eResp = (isW || isR) ? ((sel == 2'd3) ? 2'd3 : 2'd1) : 2'd0;
        eData = isR ? rd : 32'd0;
        expired = mEn && (mCyc == mDeadline);
        eIntr = expired && mMask;
        if (isW && sel == 2'd0 && ben[0]) begin
            if (mEn && !data[0]) mHeld = currNow();
            if (data[0]) begin
                mLoad = mCntr;
                mDeadline = mCyc + periodOf(mCntr);
            end
            mEn = data[0]; mRel = data[1]; mMask = data[2];
        end else if (expired) begin
            if (mRel) begin
                mLoad = mCntr;
                mDeadline = mCyc + periodOf(mCntr);
            end else begin
                mEn = 0;
                mHeld = 0;
            end
        end
        if (isW && sel == 2'd1) begin
            for (int b = 0; b < 4; b++) begin
                if (ben[b]) mCntr[8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    // One bus cycle: drive on the falling edge, sample one step after the rising edge.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] ben);
        @(negedge clk);
        bus.i_MCmd    = cmd;
        bus.i_MAddr   = addr;
        bus.i_MData   = data;
        bus.i_MByteEn = ben;
        #1;
        checkOutput("accept", 32'(bus.o_SCmdAccept), 32'(cmd == 3'd1 || cmd == 3'd2));
        @(posedge clk);
        modelStep(cmd, addr, data, ben);
        #1;
        sData = bus.o_SData;
        sResp = bus.o_SResp;
        sIntr = intr;
        checkOutput("resp", 32'(sResp), 32'(eResp));
        checkOutput("rdata", sData, eData);
        checkOutput("intr", 32'(sIntr), 32'(eIntr));
    endtask

    task automatic idleCycle();
        applyStimulus(3'd0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic waitPulse(input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            idleCycle();
            if (sIntr) begin
                cycles = k;
                break;
            end
        end
        if (cycles < 0) checkOutput("pulseTimeout", 32'hFFFF_FFFF, 32'(limit));
    endtask

    vec_t vecs[16];

    initial begin
        int gap;
        logic [31:0] c1;
        logic [2:0] rc;
        int r;

        vecs[0]  = '{3'd2, 32'h0000_0000, 32'h0,         4'hF, 2'd1, 32'h0,         1'b0};
        vecs[1]  = '{3'd2, 32'h0000_0004, 32'h0,         4'hF, 2'd1, 32'h0,         1'b0};
        vecs[2]  = '{3'd2, 32'h0000_0008, 32'h0,         4'hF, 2'd1, 32'h0,         1'b0};
        vecs[3]  = '{3'd2, 32'h0000_000C, 32'h0,         4'hF, 2'd3, 32'h0,         1'b0};
        vecs[4]  = '{3'd1, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 2'd3, 32'h0,         1'b0};
        vecs[5]  = '{3'd1, 32'h0000_0004, 32'hAABB_CCDD, 4'h3, 2'd1, 32'h0,         1'b0};
        vecs[6]  = '{3'd2, 32'h0000_0004, 32'h0,         4'h0, 2'd1, 32'h0000_CCDD, 1'b0};
        vecs[7]  = '{3'd1, 32'h0000_0008, 32'h1234_5678, 4'hF, 2'd1, 32'h0,         1'b0};
        vecs[8]  = '{3'd2, 32'h0000_0008, 32'h0,         4'h0, 2'd1, 32'h0,         1'b0};
        vecs[9]  = '{3'd1, 32'h0000_0004, 32'h0000_0010, 4'hF, 2'd1, 32'h0,         1'b0};
        vecs[10] = '{3'd2, 32'h1000_0007, 32'h0,         4'h0, 2'd1, 32'h10,        1'b0};
        vecs[11] = '{3'd1, 32'h0000_0000, 32'hFFFF_FFF6, 4'hF, 2'd1, 32'h0,         1'b0};
        vecs[12] = '{3'd2, 32'hFFFF_FF03, 32'h0,         4'h0, 2'd1, 32'h6,         1'b0};
        vecs[13] = '{3'd0, 32'h0000_0004, 32'h0,         4'h0, 2'd0, 32'h0,         1'b0};
        vecs[14] = '{3'd5, 32'h0000_0004, 32'h1,         4'hF, 2'd0, 32'h0,         1'b0};
        vecs[15] = '{3'd2, 32'h0000_0008, 32'h0,         4'h0, 2'd1, 32'h0,         1'b0};

        nrst = 1'b0;
        bus.i_MCmd = 3'd0; bus.i_MAddr = 32'd0; bus.i_MData = 32'd0; bus.i_MByteEn = 4'd0;
        modelReset();
        #23;
        checkOutput("rstResp", 32'(bus.o_SResp), 32'd0);
        checkOutput("rstData", bus.o_SData, 32'd0);
        checkOutput("rstIntr", 32'(intr), 32'd0);
        nrst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].ben);
            checkOutput($sformatf("vecResp%0d", i), 32'(sResp), 32'(vecs[i].resp));
            checkOutput($sformatf("vecData%0d", i), sData, vecs[i].rdata);
            checkOutput($sformatf("vecIntr%0d", i), 32'(sIntr), 32'(vecs[i].intr));
        end

        // Periodic mode with period 0x10, then shorten the period mid-count.
        applyStimulus(3'd1, 32'h0, 32'h7, 4'hF);
        applyStimulus(3'd2, 32'h8, 32'h0, 4'h0);
        c1 = sData;
        checkOutput("currStart", c1, 32'h10);
        applyStimulus(3'd2, 32'h0, 32'h0, 4'h0);
        checkOutput("ctrlRun", sData, 32'h7);
        idleCycle();
        idleCycle();
        applyStimulus(3'd2, 32'h8, 32'h0, 4'h0);
        checkOutput("currDelta", c1 - sData, 32'd4);
        applyStimulus(3'd2, 32'h4, 32'h0, 4'h0);
        checkOutput("cntrRun", sData, 32'h10);
        waitPulse(40, gap);
        waitPulse(40, gap);
        checkOutput("period16", 32'(gap), 32'd16);
        applyStimulus(3'd1, 32'h4, 32'h4, 4'hF);
        waitPulse(40, gap);
        checkOutput("periodOld", 32'(gap + 1), 32'd16);
        waitPulse(40, gap);
        checkOutput("periodNew1", 32'(gap), 32'd4);
        waitPulse(40, gap);
        checkOutput("periodNew2", 32'(gap), 32'd4);

        // One-shot with CNTR=4 and no interrupt.
        applyStimulus(3'd1, 32'h0, 32'h0, 4'hF);
        applyStimulus(3'd1, 32'h0, 32'h1, 4'hF);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(3'd2, 32'h8, 32'h0, 4'h0);
            checkOutput($sformatf("oneShot%0d", k), sData, (k < 4) ? 32'(4 - k) : 32'd0);
            checkOutput($sformatf("oneShotIntr%0d", k), 32'(sIntr), 32'd0);
        end
        applyStimulus(3'd2, 32'h0, 32'h0, 4'h0);
        checkOutput("oneShotCtrl", sData, 32'h0);

        // Period 1 keeps the interrupt high; reset must drop it immediately.
        applyStimulus(3'd1, 32'h4, 32'h0, 4'hF);
        applyStimulus(3'd1, 32'h0, 32'h7, 4'hF);
        idleCycle();
        idleCycle();
        checkOutput("intrBeforeRst", 32'(sIntr), 32'd1);
        #2 nrst = 1'b0;
        #1;
        checkOutput("intrAsyncRst", 32'(intr), 32'd0);
        checkOutput("respAsyncRst", 32'(bus.o_SResp), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("intrHeldRst", 32'(intr), 32'd0);
        @(negedge clk);
        #2 nrst = 1'b1;
        modelReset();
        applyStimulus(3'd2, 32'h0, 32'h0, 4'h0);
        checkOutput("rstCtrl", sData, 32'h0);
        applyStimulus(3'd2, 32'h4, 32'h0, 4'h0);
        checkOutput("rstCntr", sData, 32'h0);
        applyStimulus(3'd2, 32'h8, 32'h0, 4'h0);
        checkOutput("rstCurr", sData, 32'h0);

        // Random traffic, biased toward short periods so expiries happen often.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      rc = 3'd0;
            else if (r < 7) rc = 3'd2;
            else if (r < 9) rc = 3'd1;
            else            rc = 3'($urandom_range(3, 7));
            applyStimulus(rc, $urandom,
                          ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12)),
                          4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable down-counting interval timer with an OCP slave register port. Software loads a period, enables the timer, and optionally requests auto-reload and an interrupt. The block sits on the system OCP bus as a memory-mapped peripheral and drives one interrupt line to the interrupt controller.

## Interface
- No parameters; widths come from common defines: `ADDR_WIDTH`=32, `DATA_WIDTH`=32, `BEN_WIDTH`=4.
- clk  in  1  single clock, all logic on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- i_MAddr  in  ADDR_WIDTH  byte address; only bits [3:2] decoded, bits [1:0] and upper bits ignored.
- i_MCmd  in  3  OCP command: IDLE=0, WRITE=1, READ=2; other codes treated as IDLE.
- i_MData  in  DATA_WIDTH  write data.
- i_MByteEn  in  BEN_WIDTH  write byte enables, bit n gates data byte n.
- o_SCmdAccept  out  1  command accept.
- o_SData  out  DATA_WIDTH  read data.
- o_SResp  out  2  OCP response: NULL=0, DVA=1, ERR=3.
- o_intr  out  1  interrupt pulse.

## Operation
- Register map by i_MAddr[3:2]:
  - 0x0 CTRL (RW): bit0 enable, bit1 reload, bit2 imask (1 = interrupt enabled); bits [31:3] read 0.
  - 0x4 CNTR (RW): 32-bit period value.
  - 0x8 CURR (RO): current count; writes ignored, still DVA.
  - 0xC unmapped: read returns 0 with ERR; write ignored with ERR.
- Writes honour i_MByteEn per byte for CTRL and CNTR.
- Write to CTRL with new enable=1 loads CURR <= CNTR (restart), including when already running.
- Write to CTRL with enable=0 stops counting; CURR holds its value.
- Write to CNTR does not touch CURR; the new period takes effect at the next reload or restart.
- While enable=1, each cycle:
  - CURR > 1: CURR <= CURR-1.
  - CURR <= 1: expiry event.
- On an expiry event:
  - o_intr pulses if imask=1.
  - reload=1: CURR <= CNTR.
  - reload=0: CURR <= 0 and enable clears to 0 (one-shot).
- Period is therefore CNTR cycles per expiry, with CNTR=0 treated like 1.

## Timing
- Reset values: CTRL=0, CNTR=0, CURR=0, o_SData=0, o_SResp=NULL, o_intr=0.
- o_SCmdAccept is combinational: 1 whenever i_MCmd is READ or WRITE, else 0. No wait states.
- The write takes effect at the rising edge on which the command is presented.
- Response is registered, one cycle after the command:
  - o_SResp = DVA (or ERR) for exactly one cycle, then NULL.
  - o_SData is valid in the same cycle as the response, and 0 otherwise.
- Read data reflects register state before the accept edge.
- o_intr is registered: high for exactly one cycle, the cycle after the expiry edge. No sticky status and no acknowledge.
- Simultaneous events:
  - CTRL write coinciding with expiry: the write wins; no auto-reload/one-shot update that cycle, but the interrupt pulse is still issued if imask was 1.
  - CNTR write coinciding with a reload: the reload uses the old CNTR value.
- Back-to-back commands every cycle are supported.
- nrst assertion mid-count clears everything immediately; o_intr drops asynchronously.

## Test plan
- Reset, then read CTRL/CNTR/CURR -> each returns 0 with DVA one cycle after the read; o_intr=0.
- Write CNTR=0x10, write CTRL=0x7, read CTRL -> 0x7; read CNTR -> 0x10. Two CURR reads 4 cycles apart differ by 4. o_intr pulses one cycle wide every 16 cycles.
- While running with a period of 0x10, write CNTR=0x4 -> the current period completes at 16 cycles, then pulses occur every 4 cycles.
- Write CTRL=0x1 with CNTR=4 -> CURR counts 4,3,2,1, then 0 and stays 0; CTRL reads 0x0 afterwards; o_intr never asserts.
- Byte-enable write CNTR=0xAABBCCDD with i_MByteEn=0x3 over an old value of 0 -> CNTR reads 0x0000CCDD. Write to CURR -> DVA, value unchanged.
- Read 0xC -> ERR with data 0. Assert nrst mid-count -> all registers return to 0 and o_intr stays low.
